alu_mdu: RTL



---
 rtl/alu_mdu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// Execute-stage arithmetic: combinational ALU plus an iterative multiply/divide
// unit (shift-add multiply, restoring divide) that writes its results into HI/LO.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] s,
    input  logic             mdu_start,
    input  logic [1:0]       mdu_op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [SHW-1:0] shamt;
    logic           slt;

    assign shamt = a[SHW-1:0];
    assign slt   = $signed(a) < $signed(b);

    always_comb begin
        s = '0;
        case (aluc[1:0])
            2'b00: s = aluc[2] ? (a - b) : (a + b);
            2'b01: s = aluc[2] ? (a | b) : (a & b);
            2'b10: s = aluc[2] ? (b << (WIDTH / 2)) : (a ^ b);
            2'b11: begin
                case (aluc[3:2])
                    2'b00:   s = b << shamt;
                    2'b01:   s = b >> shamt;
                    2'b11:   s = WIDTH'($signed(b) >>> shamt);
                    default: s = {{(WIDTH-1){1'b0}}, slt};
                endcase
            end
            default: s = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply / divide unit
    // ------------------------------------------------------------------
    state_t               state_reg;
    logic [CW-1:0]        count_reg;
    logic [1:0]           op_reg;
    logic                 a_neg_reg;
    logic                 b_neg_reg;
    logic                 div_zero_reg;
    logic [WIDTH-1:0]     a_mag_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [2*WIDTH-1:0]   work_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 done_reg;

    logic                 start_a_neg;
    logic                 start_b_neg;
    logic [WIDTH-1:0]     start_a_mag;
    logic [WIDTH-1:0]     start_b_mag;

    assign start_a_neg = mdu_op[0] & a[WIDTH-1];
    assign start_b_neg = mdu_op[0] & b[WIDTH-1];
    assign start_a_mag = start_a_neg ? (-a) : a;
    assign start_b_mag = start_b_neg ? (-b) : b;

    // work_reg holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;

    assign mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]}
                     + (work_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    assign mul_next  = {mul_sum, work_reg[WIDTH-1:1]};
    assign div_shift = work_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, mcand_reg};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  work_reg[WIDTH-2:0], 1'b1};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    always_comb begin
        prod_fix = (a_neg_reg ^ b_neg_reg) ? (-work_reg) : work_reg;
        quo_fix  = (a_neg_reg ^ b_neg_reg) ? (-work_reg[WIDTH-1:0]) : work_reg[WIDTH-1:0];
        rem_fix  = a_neg_reg ? (-work_reg[2*WIDTH-1:WIDTH]) : work_reg[2*WIDTH-1:WIDTH];
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (op_reg[1]) begin
            if (div_zero_reg) begin
                // Divide by zero returns the original dividend, bypassing sign fix
                fix_lo = '1;
                fix_hi = a_neg_reg ? (-a_mag_reg) : a_mag_reg;
            end else begin
                fix_lo = quo_fix;
                fix_hi = rem_fix;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            op_reg       <= '0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            a_mag_reg    <= '0;
            mcand_reg    <= '0;
            work_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hi_we) hi_reg <= a;
                    if (lo_we) lo_reg <= a;
                    if (mdu_start) begin
                        state_reg    <= RUN;
                        count_reg    <= '0;
                        op_reg       <= mdu_op;
                        a_neg_reg    <= start_a_neg;
                        b_neg_reg    <= start_b_neg;
                        div_zero_reg <= (b == '0);
                        a_mag_reg    <= start_a_mag;
                        mcand_reg    <= start_b_mag;
                        work_reg     <= {{WIDTH{1'b0}}, start_a_mag};
                    end
                end
                RUN: begin
                    work_reg  <= op_reg[1] ? div_next : mul_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(WIDTH - 1)) state_reg <= FIX;
                end
                FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mdu_busy = (state_reg != IDLE);
    assign mdu_done = done_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule
